// File: rtl/axi_mem_pkg.sv
//==============================================================================
// Module   : axi_mem_pkg
// Brief    : Shared AXI4 burst/response encodings, FSM states and beat info.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package axi_mem_pkg;

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;
    localparam logic [1:0] c_BURST_RSVD  = 2'b11;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [2:0] c_SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  beat;
    } beat_info_t;

    // Decode error outranks a slave error for the same beat.
    function automatic logic [1:0] beat_resp(input logic in_range, input logic legal);
        if (!in_range)
            return c_RESP_DECERR;
        else if (!legal)
            return c_RESP_SLVERR;
        else
            return c_RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
//==============================================================================
// Module   : axi_burst_addr_gen
// Brief    : Next-beat address and burst legality for one AXI4 channel.
// Config   : AXI_MEM_WRAP_EN - when defined WRAP bursts are legal
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_burst_addr_gen
    import axi_mem_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    input  logic [2:0]  i_size,
    input  logic [1:0]  i_burst,
    output logic [31:0] o_next_addr,
    output logic        o_legal
);

    logic [31:0] w_wrap_mask;
    logic [31:0] w_incr_addr;
    logic        w_wrap_len_ok;

    always_comb begin
        // Window is (len+1)*4 bytes, so the in-window offset mask is len*4+3.
        w_wrap_mask = {22'd0, i_len, 2'b11};
        w_incr_addr = i_addr + 32'd4;
`ifdef AXI_MEM_WRAP_EN
        w_wrap_len_ok = (i_len == 8'd1) || (i_len == 8'd3) ||
                        (i_len == 8'd7) || (i_len == 8'd15);
`else
        w_wrap_len_ok = 1'b0;
`endif
        case (i_burst)
            c_BURST_INCR: o_next_addr = w_incr_addr;
            c_BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr_addr & w_wrap_mask);
            default:      o_next_addr = i_addr;
        endcase
        o_legal = (i_size == c_SIZE_WORD) && (i_burst != c_BURST_RSVD) &&
                  ((i_burst != c_BURST_WRAP) || w_wrap_len_ok);
    end

endmodule

`default_nettype wire

// File: rtl/axi4_mem_responder.sv
//==============================================================================
// Module   : axi4_mem_responder
// Brief    : AXI4 slave backed by a word-addressed RAM, independent rd/wr FSMs.
// Config   : AXI_MEM_WRAP_EN - when defined WRAP bursts are supported
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi4_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awregion,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arregion,
    input  logic [3:0]  s_axi_arqos,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int unsigned c_IDX_W = $clog2(MEM_WORDS);

    function automatic logic f_in_range(input logic [31:0] a);
        return (a >> (c_IDX_W + 2)) == 32'd0;
    endfunction

    logic [31:0] r_mem [MEM_WORDS];
    logic        r_ready_en;

    wire w_unused = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awregion,
                      s_axi_awqos, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_arregion, s_axi_arqos};

    // Holds both address-ready outputs low until the first edge out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_ready_en <= 1'b0;
        else
            r_ready_en <= 1'b1;
    end

    // ---------------------------------------------------------------- write --
    wr_state_t         r_wstate;
    wr_state_t         w_wstate_nxt;
    beat_info_t        r_wbi;
    logic              r_wdecerr;
    logic              r_wslverr;
    logic [31:0]       w_wnext;
    logic              w_wlegal;
    logic              w_win_range;
    logic              w_wlast_beat;
    logic              w_awfire;
    logic              w_wfire;
    logic              w_bfire;
    logic [c_IDX_W-1:0] w_widx;

    assign w_awfire     = s_axi_awvalid && s_axi_awready;
    assign w_wfire      = s_axi_wvalid && s_axi_wready;
    assign w_bfire      = s_axi_bvalid && s_axi_bready;
    assign w_win_range  = f_in_range(r_wbi.addr);
    assign w_wlast_beat = (r_wbi.beat == r_wbi.len);
    assign w_widx       = r_wbi.addr[c_IDX_W+1:2];

    axi_burst_addr_gen u_wr_addr_gen (
        .i_addr      (r_wbi.addr),
        .i_len       (r_wbi.len),
        .i_size      (r_wbi.size),
        .i_burst     (r_wbi.burst),
        .o_next_addr (w_wnext),
        .o_legal     (w_wlegal)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_wstate <= W_IDLE;
        else
            r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_awfire) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_wfire && w_wlast_beat) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_bfire) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = c_RESP_OKAY;
        case (r_wstate)
            W_IDLE:  s_axi_awready = r_ready_en;
            W_DATA:  s_axi_wready  = 1'b1;
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = beat_resp(!r_wdecerr, !r_wslverr);
            end
            default: ;
        endcase
    end

    // Error flags are sticky across the burst and summarised in the single B beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wbi     <= '0;
            r_wdecerr <= 1'b0;
            r_wslverr <= 1'b0;
        end else if (w_awfire) begin
            r_wbi     <= '{addr: s_axi_awaddr, len: s_axi_awlen, size: s_axi_awsize,
                           burst: s_axi_awburst, beat: 8'd0};
            r_wdecerr <= 1'b0;
            r_wslverr <= 1'b0;
        end else if (w_wfire) begin
            r_wbi.addr <= w_wnext;
            r_wbi.beat <= r_wbi.beat + 8'd1;
            if (!w_win_range)
                r_wdecerr <= 1'b1;
            if (!w_wlegal || (s_axi_wlast != w_wlast_beat))
                r_wslverr <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wfire && w_wlegal && w_win_range) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b])
                    r_mem[w_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read --
    rd_state_t          r_rstate;
    rd_state_t          w_rstate_nxt;
    beat_info_t         r_rbi;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic               r_rlast;
    logic               w_ridle;
    logic [31:0]        w_rg_addr;
    logic [7:0]         w_rg_len;
    logic [2:0]         w_rg_size;
    logic [1:0]         w_rg_burst;
    logic [31:0]        w_rnext;
    logic               w_rlegal;
    logic [31:0]        w_rload_addr;
    logic               w_rload_inr;
    logic               w_rload_last;
    logic               w_arfire;
    logic               w_rfire;
    logic               w_rload;
    logic [c_IDX_W-1:0] w_ridx;

    assign w_ridle  = (r_rstate == R_IDLE);
    assign w_arfire = s_axi_arvalid && s_axi_arready;
    assign w_rfire  = s_axi_rvalid && s_axi_rready;
    assign w_rload  = w_arfire || (w_rfire && !r_rlast);

    // In idle the generator judges the incoming request; afterwards the latched burst.
    assign w_rg_addr    = w_ridle ? s_axi_araddr  : r_rbi.addr;
    assign w_rg_len     = w_ridle ? s_axi_arlen   : r_rbi.len;
    assign w_rg_size    = w_ridle ? s_axi_arsize  : r_rbi.size;
    assign w_rg_burst   = w_ridle ? s_axi_arburst : r_rbi.burst;
    assign w_rload_addr = w_ridle ? s_axi_araddr  : w_rnext;
    assign w_rload_inr  = f_in_range(w_rload_addr);
    assign w_rload_last = w_ridle ? (s_axi_arlen == 8'd0) : ((r_rbi.beat + 8'd1) == r_rbi.len);
    assign w_ridx       = w_rload_addr[c_IDX_W+1:2];

    axi_burst_addr_gen u_rd_addr_gen (
        .i_addr      (w_rg_addr),
        .i_len       (w_rg_len),
        .i_size      (w_rg_size),
        .i_burst     (w_rg_burst),
        .o_next_addr (w_rnext),
        .o_legal     (w_rlegal)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_rstate <= R_IDLE;
        else
            r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_arfire) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_rfire && r_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE:  s_axi_arready = r_ready_en;
            R_DATA:  s_axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // RAM is sampled before any same-edge write lands, so a colliding beat sees old data.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rbi   <= '0;
            r_rdata <= 32'd0;
            r_rresp <= c_RESP_OKAY;
            r_rlast <= 1'b0;
        end else begin
            if (w_arfire)
                r_rbi <= '{addr: s_axi_araddr, len: s_axi_arlen, size: s_axi_arsize,
                           burst: s_axi_arburst, beat: 8'd0};
            else if (w_rfire && !r_rlast) begin
                r_rbi.addr <= w_rnext;
                r_rbi.beat <= r_rbi.beat + 8'd1;
            end
            if (w_rload) begin
                r_rdata <= (w_rlegal && w_rload_inr) ? r_mem[w_ridx] : 32'd0;
                r_rresp <= beat_resp(w_rload_inr, w_rlegal);
                r_rlast <= w_rload_last;
            end
        end
    end

    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rresp;
    assign s_axi_rlast = r_rlast;

endmodule

`default_nettype wire

// File: tb/tb_axi4_mem_responder.sv
//==============================================================================
// Module   : tb_axi4_mem_responder
// Brief    : Directed self-checking bench for axi4_mem_responder.
// Config   : AXI_MEM_WRAP_EN - selects WRAP expectations
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi4_mem_responder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wdat     [16];
    logic [31:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [1:0]  resp;

    always #5 aclk = ~aclk;

    axi4_mem_responder #(.MEM_WORDS(1024)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0),
        .s_axi_awprot(3'd0), .s_axi_awregion(4'd0), .s_axi_awqos(4'd0),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0),
        .s_axi_arprot(3'd0), .s_axi_arregion(4'd0), .s_axi_arqos(4'd0),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [3:0] strb, input bit bad_last, output logic [1:0] b);
        int n;
        awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check("aw_ready", {31'd0, awready}, 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wdat[i]; wstrb = strb; wvalid = 1'b1;
            wlast = bad_last ? (i == 0) : (i == int'(len));
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            check("w_ready", {31'd0, wready}, 32'd1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge aclk); n++; end
        check("b_valid", {31'd0, bvalid}, 32'd1);
        b = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                      input logic [2:0] size, input bit stall);
        int n;
        int beat;
        int cyc;
        bit held;
        logic [31:0] s_data;
        logic        s_last;
        logic [3:0]  pat;
        pat = 4'b1001;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_ready", {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        beat = 0; cyc = 0; held = 1'b0; s_data = '0; s_last = 1'b0;
        while (beat <= int'(len) && cyc < 200) begin
            rready = stall ? pat[cyc % 4] : 1'b1;
            if (held) begin
                check("r_hold_data", rdata, s_data);
                check("r_hold_last", {31'd0, rlast}, {31'd0, s_last});
            end
            if (rvalid && rready) begin
                got_data[beat] = rdata; got_resp[beat] = rresp; got_last[beat] = rlast;
                beat++;
                held = 1'b0;
            end else if (rvalid) begin
                s_data = rdata; s_last = rlast; held = 1'b1;
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", beat, int'(len) + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge aclk);

        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_misc",    {27'd0, bresp, rresp, rlast}, 32'd0);
        aresetn = 1'b1;
        #1;
        check("rel_awready_low", {31'd0, awready}, 32'd0);
        @(negedge aclk);
        check("rel_awready", {31'd0, awready}, 32'd1);
        check("rel_arready", {31'd0, arready}, 32'd1);

        // INCR burst write then readback
        wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
        wr(32'h10, 8'd3, 2'b01, 4'hF, 1'b0, resp);
        check("incr_bresp", {30'd0, resp}, 32'd0);
        rd(32'h10, 8'd3, 2'b01, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", got_data[i], 32'hA0 + i);
            check("incr_rresp", {30'd0, got_resp[i]}, 32'd0);
            check("incr_rlast", {31'd0, got_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Byte strobes
        wdat[0] = 32'hFFFF_FFFF;
        wr(32'h20, 8'd0, 2'b01, 4'hF, 1'b0, resp);
        wdat[0] = 32'h0;
        wr(32'h20, 8'd0, 2'b01, 4'b0101, 1'b0, resp);
        rd(32'h20, 8'd0, 2'b01, 3'd2, 1'b0);
        check("strb_rdata", got_data[0], 32'hFF00_FF00);

        // WRAP len 3 at 0x38 over a pre-filled window
        wdat[0] = 32'hC0; wdat[1] = 32'hC1; wdat[2] = 32'hC2; wdat[3] = 32'hC3;
        wr(32'h30, 8'd3, 2'b01, 4'hF, 1'b0, resp);
        wdat[0] = 32'hB0; wdat[1] = 32'hB1; wdat[2] = 32'hB2; wdat[3] = 32'hB3;
        wr(32'h38, 8'd3, 2'b10, 4'hF, 1'b0, resp);
`ifdef AXI_MEM_WRAP_EN
        check("wrap_bresp", {30'd0, resp}, 32'd0);
        rd(32'h30, 8'd3, 2'b01, 3'd2, 1'b0);
        check("wrap_mem0", got_data[0], 32'hB2);
        check("wrap_mem1", got_data[1], 32'hB3);
        check("wrap_mem2", got_data[2], 32'hB0);
        check("wrap_mem3", got_data[3], 32'hB1);
        rd(32'h38, 8'd3, 2'b10, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("wrap_rdata", got_data[i], 32'hB0 + i);
            check("wrap_rresp", {30'd0, got_resp[i]}, 32'd0);
        end
`else
        check("wrap_bresp", {30'd0, resp}, 32'd2);
        rd(32'h30, 8'd3, 2'b01, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++)
            check("wrap_nowrite", got_data[i], 32'hC0 + i);
        rd(32'h38, 8'd3, 2'b10, 3'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("wrap_rdata", got_data[i], 32'd0);
            check("wrap_rresp", {30'd0, got_resp[i]}, 32'd2);
        end
`endif

        // Out-of-range and protocol errors
        rd(32'h1000, 8'd0, 2'b01, 3'd2, 1'b0);
        check("oor_rdata", got_data[0], 32'd0);
        check("oor_rresp", {30'd0, got_resp[0]}, 32'd3);
        check("oor_rlast", {31'd0, got_last[0]}, 32'd1);
        wdat[0] = 32'hE0; wdat[1] = 32'hE1;
        wr(32'h50, 8'd1, 2'b01, 4'hF, 1'b1, resp);
        check("badlast_bresp", {30'd0, resp}, 32'd2);
        wdat[0] = 32'h5A5A_0001; wdat[1] = 32'h5A5A_0002;
        wr(32'hFFC, 8'd1, 2'b01, 4'hF, 1'b0, resp);
        check("edge_bresp", {30'd0, resp}, 32'd3);
        rd(32'hFFC, 8'd1, 2'b01, 3'd2, 1'b0);
        check("edge_rdata0", got_data[0], 32'h5A5A_0001);
        check("edge_rresp0", {30'd0, got_resp[0]}, 32'd0);
        check("edge_rdata1", got_data[1], 32'd0);
        check("edge_rresp1", {30'd0, got_resp[1]}, 32'd3);
        rd(32'h10, 8'd0, 2'b01, 3'd1, 1'b0);
        check("size_rdata", got_data[0], 32'd0);
        check("size_rresp", {30'd0, got_resp[0]}, 32'd2);

        // FIXED burst keeps hitting one word
        wdat[0] = 32'hD0; wdat[1] = 32'hD1;
        wr(32'h40, 8'd1, 2'b00, 4'hF, 1'b0, resp);
        check("fixed_bresp", {30'd0, resp}, 32'd0);
        rd(32'h40, 8'd1, 2'b00, 3'd2, 1'b0);
        check("fixed_rdata0", got_data[0], 32'hD1);
        check("fixed_rdata1", got_data[1], 32'hD1);

        // Back-pressured read
        rd(32'h10, 8'd3, 2'b01, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++)
            check("stall_rdata", got_data[i], 32'hA0 + i);
        check("stall_rlast", {31'd0, got_last[3]}, 32'd1);

        // Reset in the middle of a write burst
        awaddr = 32'h60; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        wdata = 32'h77; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        check("mid_wready", {31'd0, wready}, 32'd1);
        @(negedge aclk);
        aresetn = 1'b0; wvalid = 1'b0;
        #1;
        check("mid_rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("mid_rst_awready", {31'd0, awready}, 32'd0);
        check("mid_rst_wready",  {31'd0, wready},  32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("mid_awready", {31'd0, awready}, 32'd1);
        check("mid_bvalid",  {31'd0, bvalid},  32'd0);
        check("mid_wready_idle", {31'd0, wready}, 32'd0);
        rd(32'h10, 8'd0, 2'b01, 3'd2, 1'b0);
        check("mem_kept", got_data[0], 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_mem_responder.md
AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving memory depth in 32-bit words (power of two).
REQ-002 SHALL have port aclk, in, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port aresetn, in, 1, asynchronous active-low reset.
REQ-004 SHALL have ports s_axi_awaddr/awlen/awsize/awburst, in, 32/8/3/2, write address channel payload.
REQ-005 SHALL have ports s_axi_awvalid in 1 and s_axi_awready out 1, write address handshake.
REQ-006 SHALL have ports s_axi_wdata/wstrb/wlast/wvalid, in, 32/4/1/1, and s_axi_wready, out, 1, write data channel.
REQ-007 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1 and s_axi_bready in 1, write response channel.
REQ-008 SHALL have ports s_axi_araddr/arlen/arsize/arburst, in, 32/8/3/2, and s_axi_arvalid in 1 and s_axi_arready out 1, read address channel.
REQ-009 SHALL have ports s_axi_rdata out 32, rresp out 2, rlast out 1, rvalid out 1 and rready in 1, read data channel.
REQ-010 SHALL accept s_axi_aw/ar lock, cache, prot, region and qos inputs at AXI4 widths and ignore them.

Function
REQ-011 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; read FSM SHALL use R_IDLE, R_DATA; the two run independently.
REQ-012 awready SHALL be 1 only in W_IDLE; AW handshake latches address, len, size, burst, clears beat count, moves to W_DATA.
REQ-013 wready SHALL be 1 only in W_DATA; each W handshake writes bytes enabled by wstrb at the current word address when the burst is legal and the address is in range.
REQ-014 Handshake on beat count == awlen SHALL move to W_RESP with bvalid=1 on the next cycle; bvalid holds until bready, then W_IDLE.
REQ-015 bresp SHALL be DECERR (3) if any beat address is >= MEM_WORDS*4, else SLVERR (2) if the burst is illegal or wlast != (beat == awlen) on any beat, else OKAY (0); out-of-range beats SHALL not write.
REQ-016 arready SHALL be 1 only in R_IDLE; AR handshake moves to R_DATA with rvalid=1 and the first beat registered on the next cycle.
REQ-017 rdata/rresp/rlast SHALL be stable while rvalid && !rready; a handshake loads the next beat next cycle with no bubble; rlast=1 on beat arlen; handshake on rlast returns to R_IDLE.
REQ-018 Out-of-range read beats SHALL return rdata 0 with DECERR; illegal-burst beats SHALL return rdata 0 with SLVERR; per-beat, DECERR takes precedence.
REQ-019 Illegal burst: size != 2, burst == 2'b11, or WRAP with len not in {1,3,7,15}.
REQ-020 Next address: FIXED unchanged; INCR +4 with 32-bit wrap-around; WRAP +4 within an aligned (len+1)*4-byte window.
REQ-021 A read beat loaded in the same cycle as a write to the same word SHALL return pre-write data.

Reset
REQ-022 aresetn low SHALL force both FSMs idle and counters to 0, with outputs awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0.
REQ-023 awready and arready SHALL rise on the first aclk edge after aresetn deasserts.
REQ-024 Reset mid-burst SHALL abort it without a response; memory contents SHALL not be reset.

Configuration
REQ-025 With AXI_MEM_WRAP_EN defined, WRAP bursts SHALL follow REQ-019/020; without it, every WRAP burst SHALL be illegal (SLVERR, no writes, rdata 0).

Structure
REQ-026 Package axi_mem_pkg SHALL hold the burst and resp encodings, the FSM state enums and a beat-info struct.
REQ-027 Sub-module axi_burst_addr_gen SHALL compute the next address and the legality flag, and SHALL be instantiated once per channel.

Verification
REQ-028 AW addr 0x10, INCR, len 3, size 2, data 0xA0..0xA3, wlast on beat 3 -> bresp 0; AR of the same burst returns 0xA0..0xA3 with rlast on the 4th beat.
REQ-029 Write 0xFFFFFFFF then wstrb 4'b0101 with data 0 at 0x20 -> readback 0xFF00FF00.
REQ-030 WRAP len 3 at 0x38 -> beat addresses 0x38,0x3C,0x30,0x34 when AXI_MEM_WRAP_EN is defined; SLVERR with rdata 0 when it is not.
REQ-031 AR at MEM_WORDS*4 -> DECERR and rdata 0; AW len 1 with wlast on beat 0 -> SLVERR.
REQ-032 rready toggled 1-0-0-1 during a 4-beat read -> payload held stable while stalled, no beats lost; aresetn pulsed mid-write -> bvalid stays 0 and awready returns to 1.
